mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter CORES, default 32, meaning SIMD lanes per memory word.
REQ-002 The block SHALL have parameter BITS, default 16, meaning bits per lane; word width W = CORES*BITS.
REQ-003 The block SHALL have parameter PORTS, default 2, meaning number of processing_block requesters.
REQ-004 The block SHALL have parameter DEPTH, default 1024, meaning number of W-bit words stored.
REQ-005 The block SHALL have port clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning synchronous, active-low reset (0 = reset, sampled on clock rising edge).
REQ-007 The block SHALL have port load_ctrl, input, PORTS, meaning per-port read request.
REQ-008 The block SHALL have port write_ctrl, input, PORTS, meaning per-port write request.
REQ-009 The block SHALL have port load_addr, input, PORTS*16, meaning per-port read word address; port p is bits [p*16 +: 16].
REQ-010 The block SHALL have port write_addr_main, input, PORTS*16, meaning per-port write word address, packed like load_addr.
REQ-011 The block SHALL have port write_data_main, input, PORTS*W, meaning per-port write data; port p is bits [p*W +: W].
REQ-012 The block SHALL have port load_data, output, PORTS*W, meaning per-port registered read data.
REQ-013 The block SHALL have port grant, output, PORTS, meaning combinational, one-hot-or-zero, request accepted this cycle.
REQ-014 The block SHALL have port load_valid, output, PORTS, meaning load_data for that port updated this cycle.
REQ-015 The block SHALL have port addr_error, output, 1, meaning sticky flag for out-of-range access.
REQ-016 The block SHALL have port proto_error, output, 1, meaning sticky flag for a port asserting load_ctrl and write_ctrl together.
REQ-017 The block SHALL have port access_count, output, 32, meaning count of granted accesses.

Function
REQ-018 Port p requests when load_ctrl[p] | write_ctrl[p]; at most one request SHALL be granted per cycle.
REQ-019 Arbitration SHALL be round-robin: the winner is the first requester found scanning from pointer rr upward modulo PORTS.
REQ-020 On a grant to port g, rr SHALL become (g+1) mod PORTS at the next edge; with no grant, rr SHALL hold.
REQ-021 Non-granted requesters SHALL keep their request asserted; the block SHALL NOT queue requests, and a dropped request SHALL have no effect.
REQ-022 A granted write SHALL commit write_data_main[g] to write_addr_main[g] at that clock edge.
REQ-023 A granted read SHALL register mem[load_addr[g]] into load_data[g] and assert load_valid[g] for exactly the following cycle (latency 1).
REQ-024 load_data[p] SHALL hold its last value until the next load_valid[p].
REQ-025 A read granted the cycle after a write to the same address SHALL return the new data.
REQ-026 If both load_ctrl[g] and write_ctrl[g] are asserted, the write SHALL be serviced, the load dropped, and proto_error set.
REQ-027 An address >= DEPTH SHALL set addr_error; such a write SHALL be discarded, and such a read SHALL return all-zero data with load_valid asserted.
REQ-028 access_count SHALL increment by 1 per grant and wrap from 0xFFFFFFFF to 0.
REQ-029 addr_error and proto_error SHALL clear only on reset.

Reset
REQ-030 While reset=0 at an edge: load_valid=0, load_data=0, rr=0, addr_error=0, proto_error=0, access_count=0, and grant SHALL be forced to 0.
REQ-031 Memory contents SHALL NOT be cleared by reset, and no write SHALL occur in a cycle with reset=0.
REQ-032 A read granted the cycle before reset asserts SHALL NOT produce load_valid.

Verification
REQ-033 Port 0 writes 0xABCD in every lane to address 5, then reads address 5 -> load_valid[0] exactly 1 cycle after grant, load_data[0] = {32{16'hABCD}}.
REQ-034 Ports 0 and 1 continuously request reads from reset -> grant alternates 01,10,01,...; access_count=4 after 4 cycles.
REQ-035 Port 1 reads address 1024 (DEPTH=1024) -> load_data[1]=0, load_valid[1]=1, addr_error=1 and held until reset.
REQ-036 Port 0 asserts load_ctrl and write_ctrl with address 7, data 0x1111 -> address 7 is written, no load_valid[0], proto_error=1.
REQ-037 Reset is asserted the cycle after a read grant -> load_valid stays 0, all flags and counters are 0, and previously written address 5 still reads 0xABCD.

Source files
------------

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Single-ported, word-wide memory shared by PORTS processing blocks.
//   Each cycle at most one requester is granted, chosen round-robin starting
//   at pointer rr. A granted write commits at the clock edge. A granted read
//   returns the stored word one cycle later, on load_data/load_valid.
//
// Parameters
//   CORES  lanes per memory word
//   BITS   bits per lane (word width W = CORES*BITS)
//   PORTS  number of requesters
//   DEPTH  number of W-bit words stored
//
// Ports
//   clock            single clock, rising edge
//   reset            synchronous, active-low reset
//   load_ctrl        per-port read request
//   write_ctrl       per-port write request
//   load_addr        per-port read word address, port p at [p*16 +: 16]
//   write_addr_main  per-port write word address, same packing
//   write_data_main  per-port write data, port p at [p*W +: W]
//   load_data        per-port registered read data
//   grant            combinational one-hot-or-zero grant for this cycle
//   load_valid       load_data of that port was updated this cycle
//   addr_error       sticky: an access addressed a word >= DEPTH
//   proto_error      sticky: a granted port asserted load and write together
//   access_count     number of granted accesses, wraps at 2^32
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int CORES = 32,
    parameter int BITS  = 16,
    parameter int PORTS = 2,
    parameter int DEPTH = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PORTS-1:0]            load_ctrl,
    input  logic [PORTS-1:0]            write_ctrl,
    input  logic [PORTS*16-1:0]         load_addr,
    input  logic [PORTS*16-1:0]         write_addr_main,
    input  logic [PORTS*CORES*BITS-1:0] write_data_main,
    output logic [PORTS*CORES*BITS-1:0] load_data,
    output logic [PORTS-1:0]            grant,
    output logic [PORTS-1:0]            load_valid,
    output logic                        addr_error,
    output logic                        proto_error,
    output logic [31:0]                 access_count
);

    localparam int W   = CORES * BITS;
    localparam int RRW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]       mem_q [DEPTH];
    logic [RRW-1:0]     rr_q,        rr_d;
    logic [PORTS*W-1:0] ldata_q,     ldata_d;
    logic [PORTS-1:0]   lvalid_q,    lvalid_d;
    logic               addr_err_q,  addr_err_d;
    logic               proto_err_q, proto_err_d;
    logic [31:0]        count_q,     count_d;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [PORTS-1:0] req;
    logic             gnt_any;
    logic [RRW-1:0]   gnt_idx;

    always_comb begin
        req     = load_ctrl | write_ctrl;
        gnt_any = 1'b0;
        gnt_idx = '0;
        // First requester found scanning upward from rr, wrapping at PORTS.
        for (int i = 0; i < PORTS; i++) begin
            if (!gnt_any && req[(int'(rr_q) + i) % PORTS]) begin
                gnt_any = 1'b1;
                gnt_idx = RRW'((int'(rr_q) + i) % PORTS);
            end
        end
        grant = '0;
        // Grant is suppressed during reset so nothing downstream can act on it.
        if (gnt_any && reset) grant[gnt_idx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Selected-port decode
    // ------------------------------------------------------------------
    logic         granted;
    logic [15:0]  sel_laddr;
    logic [15:0]  sel_waddr;
    logic [W-1:0] sel_wdata;
    logic         sel_load;
    logic         sel_write;
    logic         laddr_ok;
    logic         waddr_ok;
    logic         do_write;
    logic         do_read;
    logic         mem_we;
    logic [W-1:0] rd_word;

    always_comb begin
        granted   = |grant;
        sel_laddr = load_addr[gnt_idx*16 +: 16];
        sel_waddr = write_addr_main[gnt_idx*16 +: 16];
        sel_wdata = write_data_main[gnt_idx*W +: W];
        sel_load  = load_ctrl[gnt_idx];
        sel_write = write_ctrl[gnt_idx];
        laddr_ok  = 32'(sel_laddr) < 32'(DEPTH);
        waddr_ok  = 32'(sel_waddr) < 32'(DEPTH);
        // Write wins when a port asks for both; the load is dropped.
        do_write  = granted & sel_write;
        do_read   = granted & sel_load & ~sel_write;
        // Out-of-range writes must not alias onto a low address.
        mem_we    = do_write & waddr_ok;
        rd_word   = mem_q[sel_laddr[AW-1:0]];
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        rr_d        = rr_q;
        ldata_d     = ldata_q;
        lvalid_d    = '0;
        addr_err_d  = addr_err_q;
        proto_err_d = proto_err_q;
        count_d     = count_q;

        if (granted) begin
            rr_d    = (int'(gnt_idx) == PORTS - 1) ? '0 : RRW'(int'(gnt_idx) + 1);
            count_d = count_q + 32'd1;
        end

        if (do_read) begin
            lvalid_d[gnt_idx]         = 1'b1;
            ldata_d[gnt_idx*W +: W]   = laddr_ok ? rd_word : '0;
        end

        if ((do_read && !laddr_ok) || (do_write && !waddr_ok))
            addr_err_d = 1'b1;

        if (granted && sel_load && sel_write)
            proto_err_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_q        <= '0;
            ldata_q     <= '0;
            lvalid_q    <= '0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
            count_q     <= '0;
        end else begin
            rr_q        <= rr_d;
            ldata_q     <= ldata_d;
            lvalid_q    <= lvalid_d;
            addr_err_q  <= addr_err_d;
            proto_err_q <= proto_err_d;
            count_q     <= count_d;
        end
    end

    // Storage is not reset; mem_we is already qualified by a reset-gated grant.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[sel_waddr[AW-1:0]] <= sel_wdata;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign load_data    = ldata_q;
    // A read granted just before reset asserts must not show up as valid.
    assign load_valid   = lvalid_q & {PORTS{reset}};
    assign addr_error   = addr_err_q;
    assign proto_error  = proto_err_q;
    assign access_count = count_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int CORES = 32;
    localparam int BITS  = 16;
    localparam int PORTS = 2;
    localparam int DEPTH = 1024;
    localparam int W     = CORES * BITS;

    logic                clock;
    logic                reset;
    logic [PORTS-1:0]    load_ctrl;
    logic [PORTS-1:0]    write_ctrl;
    logic [PORTS*16-1:0] load_addr;
    logic [PORTS*16-1:0] write_addr_main;
    logic [PORTS*W-1:0]  write_data_main;
    logic [PORTS*W-1:0]  load_data;
    logic [PORTS-1:0]    grant;
    logic [PORTS-1:0]    load_valid;
    logic                addr_error;
    logic                proto_error;
    logic [31:0]         access_count;

    int n_checks;
    int n_fail;

    logic [W-1:0] pat_abcd;
    logic [W-1:0] pat_1111;
    logic [W-1:0] pat_5555;
    logic [W-1:0] zero_w;

    mem_responder #(.CORES(CORES), .BITS(BITS), .PORTS(PORTS), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .load_ctrl       (load_ctrl),
        .write_ctrl      (write_ctrl),
        .load_addr       (load_addr),
        .write_addr_main (write_addr_main),
        .write_data_main (write_data_main),
        .load_data       (load_data),
        .grant           (grant),
        .load_valid      (load_valid),
        .addr_error      (addr_error),
        .proto_error     (proto_error),
        .access_count    (access_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1ns after a rising edge; registered outputs are read there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        load_ctrl       = '0;
        write_ctrl      = '0;
        load_addr       = '0;
        write_addr_main = '0;
        write_data_main = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        step();
        load_ctrl = 2'b01;
        #1;
        n_checks++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL reset_grant: got %b expected 00", grant);
        end
        step();
        n_checks++;
        if (load_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_load_valid: got %b expected 00", load_valid);
        end
        n_checks++;
        if (load_data !== {PORTS*W{1'b0}}) begin
            n_fail++; $display("FAIL reset_load_data: got nonzero expected 0");
        end
        n_checks++;
        if (addr_error !== 1'b0 || proto_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got addr=%b proto=%b expected 0 0", addr_error, proto_error);
        end
        n_checks++;
        if (access_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", access_count);
        end
        idle();
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        // rr = 0 after reset; port 0 writes ABCD pattern to address 5.
        write_ctrl = 2'b01;
        write_addr_main[15:0] = 16'd5;
        write_data_main[W-1:0] = pat_abcd;
        #1;
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL wr_grant: got %b expected 01", grant);
        end
        step();
        idle();
        load_ctrl = 2'b01;
        load_addr[15:0] = 16'd5;
        #1;
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL rd_grant: got %b expected 01", grant);
        end
        n_checks++;
        if (load_valid !== 2'b00) begin
            n_fail++; $display("FAIL rd_valid_early: got %b expected 00", load_valid);
        end
        step();
        idle();
        n_checks++;
        if (load_valid !== 2'b01) begin
            n_fail++; $display("FAIL rd_valid: got %b expected 01", load_valid);
        end
        n_checks++;
        if (load_data[W-1:0] !== pat_abcd) begin
            n_fail++; $display("FAIL rd_data: got %h expected %h", load_data[W-1:0], pat_abcd);
        end
        n_checks++;
        if (access_count !== 32'd2) begin
            n_fail++; $display("FAIL wr_rd_count: got %0d expected 2", access_count);
        end
        step();
        n_checks++;
        if (load_valid !== 2'b00 || load_data[W-1:0] !== pat_abcd) begin
            n_fail++; $display("FAIL rd_hold: got valid=%b data=%h expected 00 %h", load_valid, load_data[W-1:0], pat_abcd);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        do_reset();
        load_ctrl = 2'b11;
        load_addr = {16'd5, 16'd5};
        exp_g  = 2'b01;
        prev_g = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (grant !== exp_g) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, grant, exp_g);
            end
            n_checks++;
            if (load_valid !== prev_g) begin
                n_fail++; $display("FAIL rr_valid%0d: got %b expected %b", k, load_valid, prev_g);
            end
            step();
            prev_g = exp_g;
            exp_g  = {exp_g[0], exp_g[1]};
        end
        idle();
        n_checks++;
        if (access_count !== 32'd4) begin
            n_fail++; $display("FAIL rr_count: got %0d expected 4", access_count);
        end
        n_checks++;
        if (load_data[2*W-1:W] !== pat_abcd || load_valid !== 2'b10) begin
            n_fail++; $display("FAIL rr_p1_data: got valid=%b data=%h expected 10 %h", load_valid, load_data[2*W-1:W], pat_abcd);
        end
    endtask

    task automatic test_addr_error();
        load_ctrl = 2'b10;
        load_addr[31:16] = 16'd1024;
        #1;
        n_checks++;
        if (grant !== 2'b10) begin
            n_fail++; $display("FAIL ae_grant: got %b expected 10", grant);
        end
        step();
        idle();
        n_checks++;
        if (load_valid !== 2'b10 || load_data[2*W-1:W] !== zero_w) begin
            n_fail++; $display("FAIL ae_read: got valid=%b data=%h expected 10 0", load_valid, load_data[2*W-1:W]);
        end
        n_checks++;
        if (addr_error !== 1'b1) begin
            n_fail++; $display("FAIL ae_flag: got %b expected 1", addr_error);
        end
        // Out-of-range write to 1029 must not alias onto address 5.
        write_ctrl = 2'b01;
        write_addr_main[15:0] = 16'd1029;
        write_data_main[W-1:0] = pat_5555;
        step();
        idle();
        load_ctrl = 2'b01;
        load_addr[15:0] = 16'd5;
        step();
        idle();
        step();
        step();
        n_checks++;
        if (load_data[W-1:0] !== pat_abcd) begin
            n_fail++; $display("FAIL ae_write_discard: got %h expected %h", load_data[W-1:0], pat_abcd);
        end
        n_checks++;
        if (addr_error !== 1'b1) begin
            n_fail++; $display("FAIL ae_sticky: got %b expected 1", addr_error);
        end
    endtask

    task automatic test_proto_error();
        load_ctrl  = 2'b01;
        write_ctrl = 2'b01;
        load_addr[15:0]        = 16'd7;
        write_addr_main[15:0]  = 16'd7;
        write_data_main[W-1:0] = pat_1111;
        #1;
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL pe_grant: got %b expected 01", grant);
        end
        step();
        idle();
        n_checks++;
        if (load_valid !== 2'b00) begin
            n_fail++; $display("FAIL pe_no_valid: got %b expected 00", load_valid);
        end
        n_checks++;
        if (proto_error !== 1'b1) begin
            n_fail++; $display("FAIL pe_flag: got %b expected 1", proto_error);
        end
        load_ctrl = 2'b01;
        load_addr[15:0] = 16'd7;
        step();
        idle();
        n_checks++;
        if (load_valid !== 2'b01 || load_data[W-1:0] !== pat_1111) begin
            n_fail++; $display("FAIL pe_written: got valid=%b data=%h expected 01 %h", load_valid, load_data[W-1:0], pat_1111);
        end
    endtask

    task automatic test_reset_mid_read();
        load_ctrl = 2'b01;
        load_addr[15:0] = 16'd7;
        #1;
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL rmr_grant: got %b expected 01", grant);
        end
        step();
        idle();
        reset = 1'b0;
        #1;
        n_checks++;
        if (load_valid !== 2'b00) begin
            n_fail++; $display("FAIL rmr_valid_masked: got %b expected 00", load_valid);
        end
        step();
        n_checks++;
        if (load_valid !== 2'b00 || addr_error !== 1'b0 || proto_error !== 1'b0 || access_count !== 32'd0) begin
            n_fail++; $display("FAIL rmr_cleared: got valid=%b ae=%b pe=%b cnt=%0d expected 00 0 0 0", load_valid, addr_error, proto_error, access_count);
        end
        n_checks++;
        if (load_data !== {PORTS*W{1'b0}}) begin
            n_fail++; $display("FAIL rmr_data_cleared: got nonzero expected 0");
        end
        reset = 1'b1;
        load_ctrl = 2'b01;
        load_addr[15:0] = 16'd5;
        step();
        idle();
        n_checks++;
        if (load_valid !== 2'b01 || load_data[W-1:0] !== pat_abcd) begin
            n_fail++; $display("FAIL rmr_mem_kept: got valid=%b data=%h expected 01 %h", load_valid, load_data[W-1:0], pat_abcd);
        end
        n_checks++;
        if (access_count !== 32'd1) begin
            n_fail++; $display("FAIL rmr_count: got %0d expected 1", access_count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pat_abcd = {CORES{16'hABCD}};
        pat_1111 = {CORES{16'h1111}};
        pat_5555 = {CORES{16'h5555}};
        zero_w   = '0;
        reset    = 1'b0;
        idle();
        #1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_addr_error();
        test_proto_error();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
